// File: rtl/riscv_run_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_run_pkg
// Brief  : Shared state encoding and default parameters for the run controller
// Rev    : 1.0 - initial release
// ============================================================================
package riscv_run_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

    localparam int c_DEF_NUM_HARTS   = 1;
    localparam int c_DEF_PC_W        = 32;
    localparam int c_DEF_RST_CYCLES  = 2;
    localparam int c_DEF_MAX_CYCLES  = 52;
    localparam int c_DEF_STALL_LIMIT = 16;

endpackage
`default_nettype wire

// File: rtl/riscv_hart_monitor.sv
`default_nettype none
// ============================================================================
// Module : riscv_hart_monitor
// Brief  : Per-hart completion detector (explicit halt request or PC stall)
// Rev    : 1.0 - initial release
// ============================================================================
module riscv_hart_monitor
    import riscv_run_pkg::*;
#(
    parameter int PC_W        = c_DEF_PC_W,
    parameter int STALL_LIMIT = c_DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_instr_valid,
    input  logic            i_halt_req,
    output logic            o_halt_now,
    output logic            o_halted
);

    localparam int c_SW = $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0] r_last_pc;
    logic [c_SW-1:0] r_stall;
    logic            r_halted;

    logic w_active;
    logic w_advance;
    logic w_at_limit;
    logic w_halt_now;

    assign w_active   = i_en & ~r_halted;
    assign w_advance  = i_instr_valid & (i_pc != r_last_pc);
    assign w_at_limit = (r_stall == c_SW'(STALL_LIMIT));
    // The stall limit is judged on the registered count, so the hart is
    // flagged one cycle after the count reaches the limit.
    assign w_halt_now = w_active & (i_halt_req | w_at_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_pc <= '1;
            r_stall   <= '0;
            r_halted  <= 1'b0;
        end else if (i_clr) begin
            r_last_pc <= '1;
            r_stall   <= '0;
            r_halted  <= 1'b0;
        end else if (w_active) begin
            if (w_advance) begin
                r_last_pc <= i_pc;
                r_stall   <= '0;
            end else if (!w_at_limit) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_halt_now) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign o_halt_now = w_halt_now;
    assign o_halted   = r_halted;

endmodule
`default_nettype wire

// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : riscv_run_ctrl
// Brief  : Core reset sequencing, run-cycle budget and DONE/TIMEOUT reporting
// Rev    : 1.0 - initial release
// ============================================================================
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int NUM_HARTS   = c_DEF_NUM_HARTS,
    parameter int PC_W        = c_DEF_PC_W,
    parameter int RST_CYCLES  = c_DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = c_DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = c_DEF_STALL_LIMIT,
    parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart_i,
    input  logic [NUM_HARTS*PC_W-1:0] pc_i,
    input  logic [NUM_HARTS-1:0]      instr_valid_i,
    input  logic [NUM_HARTS-1:0]      halt_req_i,
    output logic                      core_rst_o,
    output logic                      core_clk_en_o,
    output logic                      running_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [NUM_HARTS-1:0]      hart_halted_o,
    output logic [CNT_W-1:0]          cycle_cnt_o
);

    localparam int c_HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e       r_state;
    run_state_e       w_state_nxt;
    logic [c_HW-1:0]  r_hold_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_core_rst;
    logic             r_clk_en;
    logic             r_running;
    logic             r_done;
    logic             r_timeout;

    logic                 w_restart;
    logic                 w_run;
    logic                 w_hold_last;
    logic                 w_budget_end;
    logic                 w_all_halted;
    logic [NUM_HARTS-1:0] w_halt_now;
    logic [NUM_HARTS-1:0] w_halted;

    assign w_restart    = restart_i & (r_state != ST_HOLD);
    assign w_run        = (r_state == ST_RUN);
    assign w_hold_last  = (r_hold_cnt == c_HW'(RST_CYCLES - 1));
    assign w_budget_end = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    // Harts halting this very cycle count as halted, so DONE beats TIMEOUT on a tie.
    assign w_all_halted = &(w_halted | w_halt_now);

    generate
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
            riscv_hart_monitor #(
                .PC_W       (PC_W),
                .STALL_LIMIT(STALL_LIMIT)
            ) u_mon (
                .clk          (clk),
                .rst          (rst),
                .i_clr        (w_restart),
                .i_en         (w_run),
                .i_pc         (pc_i[h*PC_W +: PC_W]),
                .i_instr_valid(instr_valid_i[h]),
                .i_halt_req   (halt_req_i[h]),
                .o_halt_now   (w_halt_now[h]),
                .o_halted     (w_halted[h])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        if (w_restart) begin
            w_state_nxt = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_hold_last) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_all_halted)      w_state_nxt = ST_DONE;
                    else if (w_budget_end) w_state_nxt = ST_TIMEOUT;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_core_rst  <= 1'b1;
            r_clk_en    <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_core_rst <= (w_state_nxt == ST_HOLD);
            r_clk_en   <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_RUN);
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_timeout  <= (w_state_nxt == ST_TIMEOUT);
            if (w_restart) begin
                r_hold_cnt  <= '0;
                r_cycle_cnt <= '0;
            end else begin
                if (r_state == ST_HOLD) begin
                    r_hold_cnt <= w_hold_last ? '0 : r_hold_cnt + 1'b1;
                end
                // The count freezes on the edge that leaves RUN.
                if (w_run && (w_state_nxt == ST_RUN)) begin
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                end
            end
        end
    end

    assign core_rst_o    = r_core_rst;
    assign core_clk_en_o = r_clk_en;
    assign running_o     = r_running;
    assign done_o        = r_done;
    assign timeout_o     = r_timeout;
    assign hart_halted_o = w_halted;
    assign cycle_cnt_o   = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_riscv_run_ctrl
// Brief  : Self-checking bench: cycle model plus directed scenarios
// Rev    : 1.0 - initial release
// ============================================================================
module tb_riscv_run_ctrl;

    localparam int A_HARTS = 2;
    localparam int A_RST   = 2;
    localparam int A_MAX   = 20;
    localparam int A_STALL = 16;
    localparam int A_CW    = $clog2(A_MAX + 1);
    localparam int B_CW    = $clog2(52 + 1);

    localparam int P_HOLD = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;
    localparam int P_TO   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              restart;
    logic [63:0]       pc;
    logic [1:0]        valid;
    logic [1:0]        halt_req;
    logic              core_rst, clk_en, running, done, timeout;
    logic [1:0]        halted;
    logic [A_CW-1:0]   cnt;

    logic              rst_b, valid_b, halt_b;
    logic [31:0]       pc_b;
    logic              core_rst_b, clk_en_b, running_b, done_b, timeout_b;
    logic [0:0]        halted_b;
    logic [B_CW-1:0]   cnt_b;
    logic              b_fin = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_run_ctrl #(
        .NUM_HARTS(A_HARTS), .PC_W(32), .RST_CYCLES(A_RST),
        .MAX_CYCLES(A_MAX), .STALL_LIMIT(A_STALL)
    ) dut (
        .clk(clk), .rst(rst), .restart_i(restart), .pc_i(pc),
        .instr_valid_i(valid), .halt_req_i(halt_req),
        .core_rst_o(core_rst), .core_clk_en_o(clk_en), .running_o(running),
        .done_o(done), .timeout_o(timeout), .hart_halted_o(halted),
        .cycle_cnt_o(cnt)
    );

    riscv_run_ctrl dut_b (
        .clk(clk), .rst(rst_b), .restart_i(1'b0), .pc_i(pc_b),
        .instr_valid_i(valid_b), .halt_req_i(halt_b),
        .core_rst_o(core_rst_b), .core_clk_en_o(clk_en_b), .running_o(running_b),
        .done_o(done_b), .timeout_o(timeout_b), .hart_halted_o(halted_b),
        .cycle_cnt_o(cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance dut ----------------
    int          m_phase, m_hold, m_cnt;
    logic [31:0] m_last [2];
    int          m_stall [2];
    bit          m_halt [2];

    task automatic m_reset();
        m_phase = P_HOLD;
        m_hold  = 0;
        m_cnt   = 0;
        for (int h = 0; h < 2; h++) begin
            m_last[h]  = 32'hFFFF_FFFF;
            m_stall[h] = 0;
            m_halt[h]  = 1'b0;
        end
    endtask

    task automatic m_run();
        bit all_h;
        bit stop;
        all_h = 1'b1;
        for (int h = 0; h < 2; h++) begin
            if (!m_halt[h]) begin
                stop = halt_req[h] || (m_stall[h] == A_STALL);
                if (valid[h] && pc[h*32 +: 32] != m_last[h]) begin
                    m_last[h]  = pc[h*32 +: 32];
                    m_stall[h] = 0;
                end else if (m_stall[h] < A_STALL) begin
                    m_stall[h] = m_stall[h] + 1;
                end
                if (stop) m_halt[h] = 1'b1;
            end
            all_h = all_h & m_halt[h];
        end
        if (all_h)                  m_phase = P_DONE;
        else if (m_cnt == A_MAX - 1) m_phase = P_TO;
        else                         m_cnt = m_cnt + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst || (restart && m_phase != P_HOLD)) begin
                m_reset();
            end else if (m_phase == P_HOLD) begin
                if (m_hold == A_RST - 1) begin
                    m_phase = P_RUN;
                    m_hold  = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end else if (m_phase == P_RUN) begin
                m_run();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("core_rst_o",    core_rst, m_phase == P_HOLD);
            chk("core_clk_en_o", clk_en,   m_phase == P_HOLD || m_phase == P_RUN);
            chk("running_o",     running,  m_phase == P_RUN);
            chk("done_o",        done,     m_phase == P_DONE);
            chk("timeout_o",     timeout,  m_phase == P_TO);
            chk("hart_halted_o", halted,   {m_halt[1], m_halt[0]});
            chk("cycle_cnt_o",   cnt,      m_cnt);
        end
    end

    // ---------------- directed stimulus for instance dut ----------------
    task automatic set_pc(input int k);
        pc = {32'h800 + 32'(4 * k), 32'h100 + 32'(4 * k)};
    endtask

    // Leaves the bench at the negedge inside RUN cycle 0.
    task automatic seq_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart core_rst", core_rst, 1);
        chk("restart done",     done,     0);
        chk("restart timeout",  timeout,  0);
        chk("restart cnt",      cnt,      0);
        chk("restart halted",   halted,   0);
        @(negedge clk);
        @(negedge clk);
        chk("restart running",  running,  1);
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; pc = '0; valid = 2'b00; halt_req = 2'b00;
        @(negedge clk);
        chk("reset core_rst",  core_rst, 1);
        chk("reset clk_en",    clk_en,   1);
        chk("reset cnt",       cnt,      0);
        rst = 1'b0;

        // Idle harts: stall detection ends the run
        @(negedge clk);
        chk("hold edge1 core_rst", core_rst, 1);
        @(negedge clk);
        chk("hold edge2 core_rst", core_rst, 0);
        chk("hold edge2 running",  running,  1);
        repeat (16) @(negedge clk);
        chk("idle c16 cnt",  cnt,  16);
        chk("idle c16 done", done, 0);
        @(negedge clk);
        chk("idle done",    done,    1);
        chk("idle timeout", timeout, 0);
        chk("idle halted",  halted,  3);
        chk("idle clk_en",  clk_en,  0);

        // Explicit halts at cycles 5 and 9
        seq_restart();
        valid = 2'b11;
        for (int k = 0; k <= 10; k++) begin
            set_pc(k);
            halt_req = {k == 9, k == 5};
            @(negedge clk);
            if (k == 5) chk("halt c5 halted", halted, 1);
            if (k == 8) chk("halt c8 done",   done,   0);
            if (k == 9) begin
                chk("halt c9 done",   done,   1);
                chk("halt c9 halted", halted, 3);
                chk("halt c9 cnt",    cnt,    9);
            end
        end
        halt_req = 2'b00;

        // Last hart halts on the budget's final cycle
        seq_restart();
        for (int k = 0; k <= 19; k++) begin
            set_pc(k);
            halt_req = {k == 19, k == 3};
            @(negedge clk);
            if (k == 18) begin
                chk("tie c19 cnt",     cnt,     19);
                chk("tie c19 timeout", timeout, 0);
            end
            if (k == 19) begin
                chk("tie done",    done,    1);
                chk("tie timeout", timeout, 0);
                chk("tie cnt",     cnt,     19);
            end
        end
        halt_req = 2'b00;

        // Always-progressing harts exhaust the budget
        seq_restart();
        for (int k = 0; k <= 19; k++) begin
            set_pc(k);
            @(negedge clk);
            if (k == 19) begin
                chk("to timeout", timeout, 1);
                chk("to done",    done,    0);
                chk("to cnt",     cnt,     19);
                chk("to clk_en",  clk_en,  0);
                chk("to halted",  halted,  0);
            end
        end

        // Restart from TIMEOUT, then async reset mid-run
        seq_restart();
        for (int k = 0; k <= 9; k++) begin
            set_pc(k);
            @(negedge clk);
        end
        chk("pre-rst cnt", cnt, 10);
        #2 rst = 1'b1;
        #1;
        chk("async core_rst", core_rst, 1);
        chk("async cnt",      cnt,      0);
        chk("async running",  running,  0);
        @(negedge clk);
        rst = 1'b0;
        valid = 2'b00;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("hold restart ignored", running, 1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 200 && !b_fin; i++) @(negedge clk);
        chk("b sequence finished", b_fin, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- instance dut_b: defaults, one hart, timeout ----------------
    initial begin
        rst_b = 1'b1; pc_b = 32'h0; valid_b = 1'b1; halt_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 1; i <= 54; i++) begin
            @(negedge clk);
            pc_b = pc_b + 32'd4;
            if (i == 1) chk("b edge1 core_rst", core_rst_b, 1);
            if (i == 2) chk("b edge2 core_rst", core_rst_b, 0);
            if (i == 53) begin
                chk("b c51 cnt",     cnt_b,     51);
                chk("b c51 timeout", timeout_b, 0);
            end
            if (i == 54) begin
                chk("b timeout",    timeout_b, 1);
                chk("b cnt",        cnt_b,     51);
                chk("b clk_en",     clk_en_b,  0);
                chk("b done",       done_b,    0);
                chk("b running",    running_b, 0);
                chk("b halted",     halted_b,  0);
            end
        end
        b_fin = 1'b1;
    end

endmodule
`default_nettype wire
